// File: rtl/modarith_pkg.sv
// Shared types for the modular-arithmetic datapath.
// The op encoding is one bit, so a single lane op can travel with each transaction.
package modarith_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam int OP_W = 1;

endpackage

// File: rtl/modarith_lane.sv
// One lane of modular add/subtract, purely combinational.
// The S1 half forms the raw W+1 bit sum or difference and the operand error flag.
// The S2 half applies the single correction step to a registered raw value.
module modarith_lane
  import modarith_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] m_i,
  input  logic [OP_W-1:0]       op_i,
  output logic [DATA_WIDTH:0]   t_o,
  output logic                  err_o,
  input  logic [DATA_WIDTH:0]   t_i,
  input  logic [DATA_WIDTH-1:0] m2_i,
  input  logic [OP_W-1:0]       op2_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  logic [DATA_WIDTH:0] mExt;

  assign mExt = {1'b0, m2_i};

  // Raw sum/difference with one extra bit.
  // For SUB the top bit doubles as the borrow, and for ADD it is the carry-out.
  always_comb begin
    t_o   = {1'b0, a_i} + {1'b0, b_i};
    err_o = (a_i >= m_i) | (b_i >= m_i) | (m_i < DATA_WIDTH'(2));
    if (op_t'(op_i) == OP_SUB) begin
      t_o = {1'b0, a_i} - {1'b0, b_i};
    end
  end

  // Single correction step.
  // With in-range operands one add or subtract of m always lands in [0, m).
  // Working on the low bits directly gives the same truncated result as the W+1 bit arithmetic.
  always_comb begin
    res_o = t_i[DATA_WIDTH-1:0];
    if (op_t'(op2_i) == OP_SUB) begin
      if (t_i[DATA_WIDTH]) begin
        res_o = t_i[DATA_WIDTH-1:0] + m2_i;
      end
    end else begin
      if (t_i >= mExt) begin
        res_o = t_i[DATA_WIDTH-1:0] - m2_i;
      end
    end
  end

endmodule

// File: rtl/modular_addsub_pipe.sv
// Two-stage pipelined, multi-lane modular add/subtract with valid/ready streaming.
// S1 holds the raw per-lane sum/difference, and S2 is the corrected output register.
// Each stage advances when it is empty or its consumer takes its contents.
module modular_addsub_pipe
  import modarith_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_W-1:0]             in_op,
  input  logic [DATA_WIDTH-1:0]       in_mod,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_res,
  output logic [LANES-1:0]            out_err
);

  localparam int TW = DATA_WIDTH + 1;

  // Stage S1 registers
  logic                        s1Valid_q, s1Valid_d;
  op_t                         s1Op_q, s1Op_d;
  logic [DATA_WIDTH-1:0]       s1Mod_q, s1Mod_d;
  logic [LANES*TW-1:0]         s1T_q, s1T_d;
  logic [LANES-1:0]            s1Err_q, s1Err_d;

  // Stage S2 / output registers
  logic                        outValid_q, outValid_d;
  logic [LANES*DATA_WIDTH-1:0] outRes_q, outRes_d;
  logic [LANES-1:0]            outErr_q, outErr_d;

  // Lane results
  logic [LANES*TW-1:0]         laneT;
  logic [LANES-1:0]            laneErr;
  logic [LANES*DATA_WIDTH-1:0] laneRes;

  logic s2Adv;
  logic s1Adv;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gLane
      modarith_lane #(
        .DATA_WIDTH(DATA_WIDTH)
      ) uLane (
        .a_i  (in_a[gi*DATA_WIDTH +: DATA_WIDTH]),
        .b_i  (in_b[gi*DATA_WIDTH +: DATA_WIDTH]),
        .m_i  (in_mod),
        .op_i (in_op),
        .t_o  (laneT[gi*TW +: TW]),
        .err_o(laneErr[gi]),
        .t_i  (s1T_q[gi*TW +: TW]),
        .m2_i (s1Mod_q),
        .op2_i(s1Op_q),
        .res_o(laneRes[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  // Stage advance conditions.
  // in_ready is forced low during reset so that nothing is accepted into a pipeline being cleared.
  always_comb begin
    s2Adv    = !outValid_q || out_ready;
    s1Adv    = !s1Valid_q || s2Adv;
    in_ready = s1Adv && !reset;
  end

  // Next-state for both stages.
  // Payload is loaded only with valid data, so a held output never changes underneath the consumer.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Op_d     = s1Op_q;
    s1Mod_d    = s1Mod_q;
    s1T_d      = s1T_q;
    s1Err_d    = s1Err_q;
    outValid_d = outValid_q;
    outRes_d   = outRes_q;
    outErr_d   = outErr_q;

    if (s1Adv) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Op_d  = op_t'(in_op);
        s1Mod_d = in_mod;
        s1T_d   = laneT;
        s1Err_d = laneErr;
      end
    end

    if (s2Adv) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        outRes_d = laneRes;
        outErr_d = s1Err_q;
      end
    end
  end

  // Pipeline registers.
  // Reset discards everything in flight and zeroes the visible outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q  <= 1'b0;
      s1Op_q     <= OP_ADD;
      s1Mod_q    <= '0;
      s1T_q      <= '0;
      s1Err_q    <= '0;
      outValid_q <= 1'b0;
      outRes_q   <= '0;
      outErr_q   <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Op_q     <= s1Op_d;
      s1Mod_q    <= s1Mod_d;
      s1T_q      <= s1T_d;
      s1Err_q    <= s1Err_d;
      outValid_q <= outValid_d;
      outRes_q   <= outRes_d;
      outErr_q   <= outErr_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_res   = outRes_q;
  assign out_err   = outErr_q;

endmodule

// File: tb/tb_modular_addsub_pipe.sv
// Self-checking bench for modular_addsub_pipe with 4 lanes of 8 bits.
// Expected results come from plain modular arithmetic held in a queue of accepted transactions.
module tb_modular_addsub_pipe;
  import modarith_pkg::*;

  localparam int W = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         inValid;
  logic         inReady;
  logic         inOp;
  logic [W-1:0] inMod;
  logic [L*W-1:0] inA;
  logic [L*W-1:0] inB;
  logic         outValid;
  logic         outReady;
  logic [L*W-1:0] outRes;
  logic [L-1:0] outErr;

  typedef struct {
    int             cyc;
    logic [L*W-1:0] res;
    logic [L-1:0]   err;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;
  int   accCnt = 0;
  int   popCnt = 0;

  always #5 clk = ~clk;

  modular_addsub_pipe #(
    .DATA_WIDTH(W),
    .LANES     (L)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_op    (inOp),
    .in_mod   (inMod),
    .in_a     (inA),
    .in_b     (inB),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_res  (outRes),
    .out_err  (outErr)
  );

  // Reference: true modular result for legal lanes; the literal one-step rule for error lanes
  function automatic void model(input logic op, input int m, input logic [L*W-1:0] a,
                                input logic [L*W-1:0] b, output logic [L*W-1:0] res,
                                output logic [L-1:0] err);
    for (int i = 0; i < L; i++) begin
      int av;
      int bv;
      int r;
      bit e;
      av = int'(a[i*W +: W]);
      bv = int'(b[i*W +: W]);
      e  = (av >= m) || (bv >= m) || (m < 2);
      if (!e) begin
        if (op) r = (((av - bv) % m) + m) % m;
        else    r = (av + bv) % m;
      end else begin
        if (!op) begin
          r = av + bv;
          if (r >= m) r = r - m;
        end else begin
          r = av - bv;
          if (r < 0) r = r + m;
        end
        r = r & ((1 << W) - 1);
      end
      res[i*W +: W] = r[W-1:0];
      err[i]        = e;
    end
  endfunction

  function automatic logic [L*W-1:0] randLanes(input int m, input bit wild);
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) begin
      if (wild) v[i*W +: W] = W'($urandom_range(0, 255));
      else      v[i*W +: W] = W'($urandom_range(0, m - 1));
    end
    return v;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic op, input logic [W-1:0] m,
                               input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                               input logic ordy);
    inValid  = v;
    inOp     = op;
    inMod    = m;
    inA      = a;
    inB      = b;
    outReady = ordy;
  endtask

  // Called between edges: checks handshake and data against the model, then records transfers
  task automatic checkOutput();
    exp_t e;
    logic expOv;
    #1;
    if (reset) begin
      checkVal("in_ready_during_reset", 32'(inReady), 32'd0);
      q.delete();
    end else begin
      checkVal("in_ready", 32'(inReady), 32'((q.size() < 2) || outReady));
      expOv = (q.size() > 0) ? (q[0].cyc <= cyc - 2) : 1'b0;
      checkVal("out_valid", 32'(outValid), 32'(expOv));
      if (outValid === 1'b1 && q.size() > 0) begin
        checkVal("out_res", outRes, q[0].res);
        checkVal("out_err", 32'(outErr), 32'(q[0].err));
        if (outReady) begin
          void'(q.pop_front());
          popCnt++;
        end
      end
      if (inValid && inReady === 1'b1) begin
        model(inOp, int'(inMod), inA, inB, e.res, e.err);
        e.cyc = cyc;
        q.push_back(e);
        accCnt++;
      end
    end
  endtask

  task automatic runCycle();
    checkOutput();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b0, 8'd251, '0, '0, 1'b1);
    for (int i = 0; i < 6 && q.size() > 0; i++) runCycle();
    checkVal("drained", 32'(q.size()), 32'd0);
  endtask

  // Single transaction with all lanes identical; checks latency and a hand-computed result
  task automatic directedTxn(input string tag, input logic op, input logic [W-1:0] m,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] expRes, input logic [L-1:0] expErr);
    int n;
    applyStimulus(1'b1, op, m, {L{a}}, {L{b}}, 1'b1);
    runCycle();
    applyStimulus(1'b0, op, m, '0, '0, 1'b1);
    n = 1;
    while (outValid !== 1'b1 && n < 8) begin
      runCycle();
      n++;
    end
    checkVal({tag, "_latency"}, 32'(n), 32'd2);
    checkVal({tag, "_res"}, outRes, {L{expRes}});
    checkVal({tag, "_err"}, 32'(outErr), 32'(expErr));
    runCycle();
  endtask

  initial begin
    int a0;
    int p0;
    int m;
    logic [L*W-1:0] av;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd251, '0, '0, 1'b1);
    repeat (3) runCycle();
    reset = 1'b0;

    $display("[TB] directed add/sub cases");
    directedTxn("add_200_100", OP_ADD, 8'd251, 8'd200, 8'd100, 8'd49, 4'h0);
    directedTxn("sub_10_20", OP_SUB, 8'd251, 8'd10, 8'd20, 8'd241, 4'h0);
    directedTxn("sub_20_10", OP_SUB, 8'd251, 8'd20, 8'd10, 8'd10, 4'h0);
    directedTxn("sub_77_77", OP_SUB, 8'd251, 8'd77, 8'd77, 8'd0, 4'h0);
    directedTxn("add_250_0", OP_ADD, 8'd251, 8'd250, 8'd0, 8'd250, 4'h0);
    directedTxn("add_255_255_m255", OP_ADD, 8'd255, 8'd255, 8'd255, 8'd255, 4'hF);
    directedTxn("add_a_eq_m", OP_ADD, 8'd251, 8'd251, 8'd3, 8'd3, 4'hF);
    directedTxn("add_m1", OP_ADD, 8'd1, 8'd0, 8'd0, 8'd0, 4'hF);

    $display("[TB] back-to-back stream");
    a0 = accCnt;
    p0 = popCnt;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'($urandom % 2), 8'd251, randLanes(251, 1'b0), randLanes(251, 1'b0), 1'b1);
      runCycle();
    end
    drain();
    checkVal("stream_accepts", 32'(accCnt - a0), 32'd40);
    checkVal("stream_results", 32'(popCnt - p0), 32'd40);

    $display("[TB] random stream with random backpressure and error lanes");
    for (int i = 0; i < 120; i++) begin
      m  = (i % 10 == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 255));
      av = randLanes((m < 2) ? 2 : m, ($urandom % 6) == 0);
      applyStimulus(1'($urandom % 4 != 0), 1'($urandom % 2), W'(m), av,
                    randLanes((m < 2) ? 2 : m, 1'b0), 1'($urandom % 3 != 0));
      runCycle();
    end
    drain();

    $display("[TB] five-cycle output stall");
    a0 = accCnt;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'($urandom % 2), 8'd251, randLanes(251, 1'b0), randLanes(251, 1'b0), 1'b0);
      runCycle();
    end
    checkVal("stall_accepts", 32'(accCnt - a0), 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom % 2), 8'd251, randLanes(251, 1'b0), randLanes(251, 1'b0), 1'b1);
      runCycle();
    end
    drain();
    checkVal("stall_no_loss", 32'(popCnt), 32'(accCnt));

    $display("[TB] reset with both stages full");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, OP_ADD, 8'd251, randLanes(251, 1'b0), randLanes(251, 1'b0), 1'b0);
      runCycle();
    end
    checkVal("full_before_reset", 32'(q.size()), 32'd2);
    reset = 1'b1;
    applyStimulus(1'b1, OP_SUB, 8'd251, randLanes(251, 1'b0), randLanes(251, 1'b0), 1'b0);
    runCycle();
    reset = 1'b0;
    applyStimulus(1'b0, OP_ADD, 8'd251, '0, '0, 1'b1);
    checkVal("post_reset_out_valid", 32'(outValid), 32'd0);
    checkVal("post_reset_out_res", outRes, 32'd0);
    checkVal("post_reset_out_err", 32'(outErr), 32'd0);
    repeat (5) runCycle();
    directedTxn("after_reset_sub", OP_SUB, 8'd251, 8'd5, 8'd9, 8'd247, 4'h0);

    checkVal("final_queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
